// File: rtl/axi4_master_engine.sv
// AXI4 burst master: queued read/write commands, several bursts in flight per
// direction, pass-through W/R data streams and per-burst worst-case completion status.
module axi4_master_engine #(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 64,
  parameter int ID_WIDTH          = 4,
  parameter int MAX_OUTSTANDING_W = 4,
  parameter int MAX_OUTSTANDING_R = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_rw,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [7:0]              i_cmd_len,
  input  logic [1:0]              i_cmd_burst,
  input  logic [ID_WIDTH-1:0]     i_cmd_id,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
  output logic                    o_rd_valid,
  input  logic                    i_rd_ready,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic [ID_WIDTH-1:0]     o_rd_id,
  output logic [1:0]              o_rd_resp,
  output logic                    o_rd_last,
  output logic                    o_wdone_valid,
  output logic [ID_WIDTH-1:0]     o_wdone_id,
  output logic [1:0]              o_wdone_resp,
  output logic                    o_rdone_valid,
  output logic [ID_WIDTH-1:0]     o_rdone_id,
  output logic [1:0]              o_rdone_resp,
  output logic [ID_WIDTH-1:0]     o_awid,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic [7:0]              o_awlen,
  output logic [2:0]              o_awsize,
  output logic [1:0]              o_awburst,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [DATA_WIDTH/8-1:0] o_wstrb,
  output logic                    o_wlast,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  input  logic [ID_WIDTH-1:0]     i_bid,
  input  logic [1:0]              i_bresp,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  output logic [ID_WIDTH-1:0]     o_arid,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  output logic [7:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  output logic                    o_arvalid,
  input  logic                    i_arready,
  input  logic [ID_WIDTH-1:0]     i_rid,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rlast,
  input  logic                    i_rvalid,
  output logic                    o_rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam int WCW   = $clog2(MAX_OUTSTANDING_W + 1);
  localparam int RCW   = $clog2(MAX_OUTSTANDING_R + 1);
  localparam int PW    = (MAX_OUTSTANDING_W > 1) ? $clog2(MAX_OUTSTANDING_W) : 1;
  localparam int NID   = 1 << ID_WIDTH;
  localparam logic [WCW-1:0] W_MAX  = WCW'(MAX_OUTSTANDING_W);
  localparam logic [RCW-1:0] R_MAX  = RCW'(MAX_OUTSTANDING_R);
  localparam logic [PW-1:0]  P_LAST = PW'(MAX_OUTSTANDING_W - 1);

  logic                  r_active;
  logic                  r_awvalid, r_arvalid;
  logic [ID_WIDTH-1:0]   r_awid, r_arid;
  logic [ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [7:0]            r_awlen, r_arlen, r_beatCnt;
  logic [2:0]            r_awsize, r_arsize;
  logic [1:0]            r_awburst, r_arburst;
  logic [WCW-1:0]        r_wOut, r_fifoCount;
  logic [RCW-1:0]        r_rOut;
  logic [7:0]            r_lenFifo [MAX_OUTSTANDING_W];
  logic [PW-1:0]         r_wrPtr, r_rdPtr;
  logic [1:0]            r_respTable [NID];
  logic                  r_wdoneValid, r_rdoneValid, r_wPendValid, r_rPendValid;
  logic [ID_WIDTH-1:0]   r_wdoneId, r_rdoneId, r_wPendId, r_rPendId;
  logic [1:0]            r_wdoneResp, r_rdoneResp;

  logic [ADDR_WIDTH-1:0] w_alignAddr;
  logic [31:0]           w_incrEnd;
  logic                  w_legal, w_wrReady, w_rdReady, w_cmdHs;
  logic                  w_issueW, w_issueR, w_illW, w_illR;
  logic                  w_fifoNonEmpty, w_fifoFull, w_wHs, w_wLast;
  logic                  w_bHs, w_rHs, w_rlastHs;
  logic [1:0]            w_rNorm, w_acc;

  assign w_alignAddr = i_cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
  assign w_incrEnd   = {20'd0, w_alignAddr[11:0]} + (({24'd0, i_cmd_len} + 32'd1) << SIZE);

  // Reserved burst encoding 2'b11 is rejected like any other illegal command.
  always_comb begin
    w_legal = 1'b0;
    case (i_cmd_burst)
      2'b00:   w_legal = (i_cmd_len <= 8'd15);
      2'b01:   w_legal = (w_incrEnd <= 32'd4096);
      2'b10:   w_legal = (i_cmd_len == 8'd1) || (i_cmd_len == 8'd3) ||
                         (i_cmd_len == 8'd7) || (i_cmd_len == 8'd15);
      default: w_legal = 1'b0;
    endcase
  end

  assign w_fifoNonEmpty = (r_fifoCount != '0);
  assign w_fifoFull     = (r_fifoCount == W_MAX);
  assign w_bHs          = i_bvalid;
  assign w_rHs          = i_rvalid & i_rd_ready & r_active;
  assign w_rlastHs      = w_rHs & i_rlast;

  // A parked local done holds off its direction so the single pending slot never overflows.
  assign w_wrReady = !r_awvalid && ((r_wOut < W_MAX) || w_bHs) && !w_fifoFull && !r_wPendValid;
  assign w_rdReady = !r_arvalid && ((r_rOut < R_MAX) || w_rlastHs) && !r_rPendValid;
  assign o_cmd_ready = r_active & (i_cmd_rw ? w_rdReady : w_wrReady);
  assign w_cmdHs   = i_cmd_valid & o_cmd_ready;
  assign w_issueW  = w_cmdHs & !i_cmd_rw & w_legal;
  assign w_illW    = w_cmdHs & !i_cmd_rw & !w_legal;
  assign w_issueR  = w_cmdHs & i_cmd_rw & w_legal;
  assign w_illR    = w_cmdHs & i_cmd_rw & !w_legal;

  assign w_wHs      = i_wr_valid & i_wready & w_fifoNonEmpty;
  assign w_wLast    = w_fifoNonEmpty & (r_beatCnt == r_lenFifo[r_rdPtr]);
  assign o_wvalid   = i_wr_valid & w_fifoNonEmpty;
  assign o_wr_ready = i_wready & w_fifoNonEmpty;
  assign o_wlast    = w_wLast;
  assign o_wdata    = i_wr_data;
  assign o_wstrb    = i_wr_strb;
  assign o_bready   = 1'b1;

  assign o_rready   = i_rd_ready & r_active;
  assign o_rd_valid = i_rvalid & r_active;
  assign o_rd_data  = i_rdata;
  assign o_rd_id    = i_rid;
  assign o_rd_resp  = i_rresp;
  assign o_rd_last  = i_rlast;

  // EXOKAY ranks as OKAY; after that the encodings order by severity numerically.
  assign w_rNorm = (i_rresp == 2'b01) ? 2'b00 : i_rresp;
  assign w_acc   = (w_rNorm > r_respTable[i_rid]) ? w_rNorm : r_respTable[i_rid];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_awvalid <= 1'b0;  r_awid <= '0;  r_awaddr <= '0;  r_awlen <= '0;
      r_awsize  <= '0;    r_awburst <= '0;
      r_arvalid <= 1'b0;  r_arid <= '0;  r_araddr <= '0;  r_arlen <= '0;
      r_arsize  <= '0;    r_arburst <= '0;
      r_wOut    <= '0;    r_rOut <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_issueW) begin
        r_awvalid <= 1'b1;  r_awid <= i_cmd_id;  r_awaddr <= w_alignAddr;
        r_awlen   <= i_cmd_len;  r_awsize <= 3'(SIZE);  r_awburst <= i_cmd_burst;
      end else if (r_awvalid && i_awready) begin
        r_awvalid <= 1'b0;
      end
      if (w_issueR) begin
        r_arvalid <= 1'b1;  r_arid <= i_cmd_id;  r_araddr <= w_alignAddr;
        r_arlen   <= i_cmd_len;  r_arsize <= 3'(SIZE);  r_arburst <= i_cmd_burst;
      end else if (r_arvalid && i_arready) begin
        r_arvalid <= 1'b0;
      end
      if (w_issueW && !w_bHs)      r_wOut <= r_wOut + 1'b1;
      else if (!w_issueW && w_bHs) r_wOut <= r_wOut - 1'b1;
      if (w_issueR && !w_rlastHs)      r_rOut <= r_rOut + 1'b1;
      else if (!w_issueR && w_rlastHs) r_rOut <= r_rOut - 1'b1;
    end
  end

  // Burst lengths queue here so W beats can run ahead of the AW handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTSTANDING_W; i++) r_lenFifo[i] <= '0;
      r_wrPtr <= '0;  r_rdPtr <= '0;  r_fifoCount <= '0;  r_beatCnt <= '0;
    end else begin
      if (w_issueW) begin
        r_lenFifo[r_wrPtr] <= i_cmd_len;
        r_wrPtr <= (r_wrPtr == P_LAST) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_wHs) begin
        if (w_wLast) begin
          r_beatCnt <= '0;
          r_rdPtr   <= (r_rdPtr == P_LAST) ? '0 : r_rdPtr + 1'b1;
        end else begin
          r_beatCnt <= r_beatCnt + 1'b1;
        end
      end
      if (w_issueW && !(w_wHs && w_wLast))      r_fifoCount <= r_fifoCount + 1'b1;
      else if (!w_issueW && (w_wHs && w_wLast)) r_fifoCount <= r_fifoCount - 1'b1;
    end
  end

  // Bus completions take priority; a colliding illegal-command done waits one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdoneValid <= 1'b0;  r_wdoneId <= '0;  r_wdoneResp <= '0;
      r_wPendValid <= 1'b0;  r_wPendId <= '0;
      r_rdoneValid <= 1'b0;  r_rdoneId <= '0;  r_rdoneResp <= '0;
      r_rPendValid <= 1'b0;  r_rPendId <= '0;
      for (int i = 0; i < NID; i++) r_respTable[i] <= '0;
    end else begin
      r_wdoneValid <= 1'b0;
      if (w_bHs) begin
        r_wdoneValid <= 1'b1;  r_wdoneId <= i_bid;  r_wdoneResp <= i_bresp;
        if (w_illW) begin
          r_wPendValid <= 1'b1;  r_wPendId <= i_cmd_id;
        end
      end else if (r_wPendValid) begin
        r_wdoneValid <= 1'b1;  r_wdoneId <= r_wPendId;  r_wdoneResp <= 2'b10;
        r_wPendValid <= 1'b0;
      end else if (w_illW) begin
        r_wdoneValid <= 1'b1;  r_wdoneId <= i_cmd_id;  r_wdoneResp <= 2'b10;
      end

      r_rdoneValid <= 1'b0;
      if (w_rHs) r_respTable[i_rid] <= i_rlast ? 2'b00 : w_acc;
      if (w_rlastHs) begin
        r_rdoneValid <= 1'b1;  r_rdoneId <= i_rid;  r_rdoneResp <= w_acc;
        if (w_illR) begin
          r_rPendValid <= 1'b1;  r_rPendId <= i_cmd_id;
        end
      end else if (r_rPendValid) begin
        r_rdoneValid <= 1'b1;  r_rdoneId <= r_rPendId;  r_rdoneResp <= 2'b10;
        r_rPendValid <= 1'b0;
      end else if (w_illR) begin
        r_rdoneValid <= 1'b1;  r_rdoneId <= i_cmd_id;  r_rdoneResp <= 2'b10;
      end
    end
  end

  assign o_awvalid = r_awvalid;  assign o_awid = r_awid;  assign o_awaddr = r_awaddr;
  assign o_awlen   = r_awlen;    assign o_awsize = r_awsize;  assign o_awburst = r_awburst;
  assign o_arvalid = r_arvalid;  assign o_arid = r_arid;  assign o_araddr = r_araddr;
  assign o_arlen   = r_arlen;    assign o_arsize = r_arsize;  assign o_arburst = r_arburst;
  assign o_wdone_valid = r_wdoneValid;  assign o_wdone_id = r_wdoneId;  assign o_wdone_resp = r_wdoneResp;
  assign o_rdone_valid = r_rdoneValid;  assign o_rdone_id = r_rdoneId;  assign o_rdone_resp = r_rdoneResp;

endmodule

// File: tb/tb_axi4_master_engine.sv
// Directed self-checking bench for axi4_master_engine with hand-computed expectations
// (64-bit data, so beat size is 8 bytes and awsize/arsize is 3).
module tb_axi4_master_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cmdValid, cmdReady, cmdRw;
  logic [31:0] cmdAddr;
  logic [7:0]  cmdLen;
  logic [1:0]  cmdBurst;
  logic [3:0]  cmdId;
  logic        wrValid, wrReady;
  logic [63:0] wrData;
  logic [7:0]  wrStrb;
  logic        rdValid, rdReady, rdLast;
  logic [63:0] rdData;
  logic [3:0]  rdId;
  logic [1:0]  rdResp;
  logic        wdoneValid, rdoneValid;
  logic [3:0]  wdoneId, rdoneId;
  logic [1:0]  wdoneResp, rdoneResp;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, arvalid, arready;
  logic [63:0] wdata, rdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  int checkCount = 0;
  int passCount  = 0;

  axi4_master_engine dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady), .i_cmd_rw(cmdRw), .i_cmd_addr(cmdAddr),
    .i_cmd_len(cmdLen), .i_cmd_burst(cmdBurst), .i_cmd_id(cmdId),
    .i_wr_valid(wrValid), .o_wr_ready(wrReady), .i_wr_data(wrData), .i_wr_strb(wrStrb),
    .o_rd_valid(rdValid), .i_rd_ready(rdReady), .o_rd_data(rdData), .o_rd_id(rdId),
    .o_rd_resp(rdResp), .o_rd_last(rdLast),
    .o_wdone_valid(wdoneValid), .o_wdone_id(wdoneId), .o_wdone_resp(wdoneResp),
    .o_rdone_valid(rdoneValid), .o_rdone_id(rdoneId), .o_rdone_resp(rdoneResp),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize), .o_awburst(awburst),
    .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast), .o_wvalid(wvalid), .i_wready(wready),
    .i_bid(bid), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize), .o_arburst(arburst),
    .o_arvalid(arvalid), .i_arready(arready),
    .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast), .i_rvalid(rvalid),
    .o_rready(rready)
  );

  // Counts one comparison and reports it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else passCount++;
  endtask

  // Advances to just after the next rising edge so inputs and samples sit away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command and holds it (bounded) until the engine takes it.
  task automatic applyStimulus(input logic rw, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    cmdValid = 1'b1;  cmdRw = rw;  cmdAddr = addr;  cmdLen = len;  cmdBurst = burst;  cmdId = id;
    #1;
    while (!cmdReady && n < 20) begin
      tick();
      #1;
      n++;
    end
    checkOutput("cmd_accept", {63'd0, cmdReady}, 64'd1);
    tick();
    cmdValid = 1'b0;
  endtask

  // Drives one R beat and checks its forwarding downstream before the edge.
  task automatic sendRBeat(input logic [3:0] id, input logic [1:0] resp, input logic last,
                           input logic [63:0] data);
    rvalid = 1'b1;  rid = id;  rresp = resp;  rlast = last;  rdata = data;
    #1;
    checkOutput("rd_valid", {63'd0, rdValid}, 64'd1);
    checkOutput("rd_data", rdData, data);
    tick();
    rvalid = 1'b0;  rlast = 1'b0;
  endtask

  logic [1:0] wrapResp [4];

  initial begin
    cmdValid = 0;  cmdRw = 0;  cmdAddr = 0;  cmdLen = 0;  cmdBurst = 0;  cmdId = 0;
    wrValid = 0;  wrData = 0;  wrStrb = 8'hFF;  rdReady = 1;
    awready = 0;  wready = 1;  bid = 0;  bresp = 0;  bvalid = 0;
    arready = 0;  rid = 0;  rdata = 0;  rresp = 0;  rlast = 0;  rvalid = 0;
    wrapResp[0] = 2'b00;  wrapResp[1] = 2'b10;  wrapResp[2] = 2'b00;  wrapResp[3] = 2'b00;

    #12;
    checkOutput("reset cmd_ready", {63'd0, cmdReady}, 64'd0);
    checkOutput("reset awvalid", {63'd0, awvalid}, 64'd0);
    checkOutput("reset arvalid", {63'd0, arvalid}, 64'd0);
    checkOutput("reset awaddr", {32'd0, awaddr}, 64'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("post-reset cmd_ready", {63'd0, cmdReady}, 64'd1);

    $display("[TB] single INCR write burst");
    applyStimulus(1'b0, 32'h100, 8'd7, 2'b01, 4'd3);
    checkOutput("wr awvalid", {63'd0, awvalid}, 64'd1);
    checkOutput("wr awaddr", {32'd0, awaddr}, 64'h100);
    checkOutput("wr awlen", {56'd0, awlen}, 64'd7);
    checkOutput("wr awsize", {61'd0, awsize}, 64'd3);
    checkOutput("wr awburst", {62'd0, awburst}, 64'd1);
    checkOutput("wr awid", {60'd0, awid}, 64'd3);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    checkOutput("wr awvalid drop", {63'd0, awvalid}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      wrValid = 1'b1;  wrData = 64'hA000 + 64'(i);
      #1;
      checkOutput("wr wlast", {63'd0, wlast}, (i == 7) ? 64'd1 : 64'd0);
      if (i == 0) checkOutput("wr wdata", wdata, 64'hA000);
      tick();
    end
    wrValid = 1'b0;
    #1;
    checkOutput("wr wvalid idle", {63'd0, wvalid}, 64'd0);
    bvalid = 1'b1;  bid = 4'd3;  bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    checkOutput("wdone valid", {63'd0, wdoneValid}, 64'd1);
    checkOutput("wdone id", {60'd0, wdoneId}, 64'd3);
    checkOutput("wdone resp", {62'd0, wdoneResp}, 64'd0);
    tick();
    checkOutput("wdone pulse end", {63'd0, wdoneValid}, 64'd0);

    $display("[TB] outstanding write limit");
    awready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h200 + 32'(i * 8), 8'd0, 2'b01, 4'(i));
    wrValid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    wrValid = 1'b0;
    cmdValid = 1'b1;  cmdRw = 1'b0;  cmdAddr = 32'h220;  cmdLen = 0;  cmdBurst = 2'b01;  cmdId = 4'd4;
    #1;
    checkOutput("limit cmd_ready low", {63'd0, cmdReady}, 64'd0);
    bvalid = 1'b1;  bid = 4'd0;  bresp = 2'b00;
    #1;
    checkOutput("limit cmd_ready with B", {63'd0, cmdReady}, 64'd1);
    tick();
    bvalid = 1'b0;  cmdValid = 1'b0;
    checkOutput("limit wdone id0", {60'd0, wdoneId}, 64'd0);
    checkOutput("fifth awvalid", {63'd0, awvalid}, 64'd1);
    checkOutput("fifth awid", {60'd0, awid}, 64'd4);
    tick();
    wrValid = 1'b1;
    tick();
    wrValid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      bvalid = 1'b1;  bid = 4'(i);  bresp = 2'b00;
      tick();
      bvalid = 1'b0;
      checkOutput("drain wdone id", {60'd0, wdoneId}, 64'(i));
    end
    tick();
    checkOutput("drain wdone end", {63'd0, wdoneValid}, 64'd0);
    awready = 1'b0;

    $display("[TB] WRAP read with SLVERR beat");
    applyStimulus(1'b1, 32'h1038, 8'd3, 2'b10, 4'd5);
    checkOutput("rd arvalid", {63'd0, arvalid}, 64'd1);
    checkOutput("rd araddr", {32'd0, araddr}, 64'h1038);
    checkOutput("rd arburst", {62'd0, arburst}, 64'd2);
    checkOutput("rd arlen", {56'd0, arlen}, 64'd3);
    checkOutput("rd arsize", {61'd0, arsize}, 64'd3);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int i = 0; i < 4; i++) sendRBeat(4'd5, wrapResp[i], i == 3, 64'hB000 + 64'(i));
    checkOutput("rdone valid", {63'd0, rdoneValid}, 64'd1);
    checkOutput("rdone id", {60'd0, rdoneId}, 64'd5);
    checkOutput("rdone resp", {62'd0, rdoneResp}, 64'd2);

    $display("[TB] illegal commands and 4KB boundary");
    applyStimulus(1'b0, 32'h300, 8'd5, 2'b10, 4'd6);
    checkOutput("ill wrap awvalid", {63'd0, awvalid}, 64'd0);
    checkOutput("ill wrap wdone", {63'd0, wdoneValid}, 64'd1);
    checkOutput("ill wrap wdone id", {60'd0, wdoneId}, 64'd6);
    checkOutput("ill wrap wdone resp", {62'd0, wdoneResp}, 64'd2);
    wrValid = 1'b1;
    #1;
    checkOutput("ill wrap no wvalid", {63'd0, wvalid}, 64'd0);
    wrValid = 1'b0;
    applyStimulus(1'b1, 32'hFF8, 8'd1, 2'b01, 4'd9);
    checkOutput("ill incr arvalid", {63'd0, arvalid}, 64'd0);
    checkOutput("ill incr rdone", {63'd0, rdoneValid}, 64'd1);
    checkOutput("ill incr rdone id", {60'd0, rdoneId}, 64'd9);
    checkOutput("ill incr rdone resp", {62'd0, rdoneResp}, 64'd2);
    applyStimulus(1'b0, 32'h400, 8'd16, 2'b00, 4'd13);
    checkOutput("ill fixed wdone id", {60'd0, wdoneId}, 64'd13);
    checkOutput("ill fixed wdone resp", {62'd0, wdoneResp}, 64'd2);
    applyStimulus(1'b1, 32'hFF0, 8'd1, 2'b01, 4'd10);
    checkOutput("edge incr arvalid", {63'd0, arvalid}, 64'd1);
    checkOutput("edge incr araddr", {32'd0, araddr}, 64'hFF0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    sendRBeat(4'd10, 2'b01, 1'b0, 64'hC0);
    sendRBeat(4'd10, 2'b00, 1'b1, 64'hC1);
    checkOutput("edge rdone id", {60'd0, rdoneId}, 64'd10);
    checkOutput("edge rdone exokay", {62'd0, rdoneResp}, 64'd0);

    $display("[TB] local done colliding with bus done");
    awready = 1'b1;
    applyStimulus(1'b0, 32'h500, 8'd0, 2'b01, 4'd11);
    wrValid = 1'b1;
    tick();
    wrValid = 1'b0;
    cmdValid = 1'b1;  cmdRw = 1'b0;  cmdAddr = 32'h600;  cmdLen = 8'd2;  cmdBurst = 2'b10;  cmdId = 4'd12;
    bvalid = 1'b1;  bid = 4'd11;  bresp = 2'b00;
    #1;
    checkOutput("collide cmd_ready", {63'd0, cmdReady}, 64'd1);
    tick();
    cmdValid = 1'b0;  bvalid = 1'b0;
    checkOutput("collide bus first", {60'd0, wdoneId}, 64'd11);
    checkOutput("collide bus resp", {62'd0, wdoneResp}, 64'd0);
    tick();
    checkOutput("collide local valid", {63'd0, wdoneValid}, 64'd1);
    checkOutput("collide local id", {60'd0, wdoneId}, 64'd12);
    checkOutput("collide local resp", {62'd0, wdoneResp}, 64'd2);
    tick();
    checkOutput("collide done end", {63'd0, wdoneValid}, 64'd0);
    awready = 1'b0;

    $display("[TB] interleaved reads");
    arready = 1'b1;
    applyStimulus(1'b1, 32'h2000, 8'd1, 2'b01, 4'd1);
    applyStimulus(1'b1, 32'h3000, 8'd1, 2'b01, 4'd2);
    tick();
    arready = 1'b0;
    sendRBeat(4'd1, 2'b00, 1'b0, 64'h10);
    sendRBeat(4'd2, 2'b11, 1'b0, 64'h20);
    sendRBeat(4'd1, 2'b00, 1'b1, 64'h11);
    checkOutput("ilv rdone id1", {60'd0, rdoneId}, 64'd1);
    checkOutput("ilv rdone resp1", {62'd0, rdoneResp}, 64'd0);
    sendRBeat(4'd2, 2'b00, 1'b1, 64'h21);
    checkOutput("ilv rdone id2", {60'd0, rdoneId}, 64'd2);
    checkOutput("ilv rdone resp2", {62'd0, rdoneResp}, 64'd3);

    $display("[TB] reset during write burst");
    applyStimulus(1'b0, 32'h700, 8'd7, 2'b01, 4'd7);
    wrValid = 1'b1;
    tick();
    tick();
    #1;
    checkOutput("pre-reset wvalid", {63'd0, wvalid}, 64'd1);
    checkOutput("pre-reset awvalid", {63'd0, awvalid}, 64'd1);
    rvalid = 1'b1;  rid = 4'd7;
    rst_n = 1'b0;
    #1;
    checkOutput("in-reset wvalid", {63'd0, wvalid}, 64'd0);
    checkOutput("in-reset awvalid", {63'd0, awvalid}, 64'd0);
    checkOutput("in-reset rd_valid", {63'd0, rdValid}, 64'd0);
    checkOutput("in-reset cmd_ready", {63'd0, cmdReady}, 64'd0);
    tick();
    wrValid = 1'b0;  rvalid = 1'b0;
    rst_n = 1'b1;
    tick();
    checkOutput("after reset cmd_ready", {63'd0, cmdReady}, 64'd1);
    checkOutput("after reset no wdone", {63'd0, wdoneValid}, 64'd0);
    wrValid = 1'b1;
    #1;
    checkOutput("after reset fifo empty", {63'd0, wvalid}, 64'd0);
    wrValid = 1'b0;
    tick();
    checkOutput("after reset still no wdone", {63'd0, wdoneValid}, 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
